// File: rtl/matrix_mult_controller.sv
// Sequencer for C = A x B: walks (i,j,k), strobes A/B reads, steers an external MAC,
// and hands each finished C element to a sink with a ready handshake.
module matrix_mult_controller #(
    parameter int AROWS    = 3,
    parameter int ACOLUMNS = 3,
    parameter int BCOLUMNS = 3,
    parameter int ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_addr,
    input  logic              c_wr_ready,
    output logic [ADDR_W-1:0] i,
    output logic [ADDR_W-1:0] j,
    output logic [ADDR_W-1:0] k
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] I_LAST   = ADDR_W'(AROWS - 1);
    localparam logic [ADDR_W-1:0] J_LAST   = ADDR_W'(BCOLUMNS - 1);
    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(ACOLUMNS - 1);
    localparam logic [ADDR_W-1:0] A_STRIDE = ADDR_W'(ACOLUMNS);
    localparam logic [ADDR_W-1:0] B_STRIDE = ADDR_W'(BCOLUMNS);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] i_next;
    logic [ADDR_W-1:0] j_next;
    logic [ADDR_W-1:0] k_next;

    // acc_en/acc_clear are the read strobe delayed to line up with memory data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            acc_en    <= 1'b0;
            acc_clear <= 1'b0;
        end else begin
            state     <= state_next;
            i         <= i_next;
            j         <= j_next;
            k         <= k_next;
            acc_en    <= rd_en;
            acc_clear <= rd_en && (k == '0);
        end
    end

    always_comb begin
        state_next = state;
        i_next     = i;
        j_next     = j;
        k_next     = k;
        rd_en      = 1'b0;
        c_wr_en    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                rd_en = 1'b1;
                if (k < K_LAST) begin
                    k_next = k + ONE;
                end else begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = WRITE;
            end
            WRITE: begin
                c_wr_en = 1'b1;
                // Indices only advance once the sink has taken the element.
                if (c_wr_ready) begin
                    if (j < J_LAST) begin
                        j_next     = j + ONE;
                        k_next     = '0;
                        state_next = RUN;
                    end else if (i < I_LAST) begin
                        j_next     = '0;
                        i_next     = i + ONE;
                        k_next     = '0;
                        state_next = RUN;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                i_next     = '0;
                j_next     = '0;
                k_next     = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy   = (state != IDLE);
    assign a_addr = i * A_STRIDE + k;
    assign b_addr = k * B_STRIDE + j;
    assign c_addr = i * B_STRIDE + j;

endmodule

// File: tb/tb_matrix_mult_controller.sv
// Self-checking bench for matrix_mult_controller: a per-pass expected-cycle list model,
// a MAC scoreboard over random A/B, and literal timing pins.
module tb_matrix_mult_controller;

    localparam int AR        = 2;
    localparam int AC        = 3;
    localparam int BC        = 4;
    localparam int AW        = 16;
    localparam int PASS_DONE = AR * BC * (AC + 2) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          c_wr_ready = 1'b1;
    logic          busy, done, rd_en, acc_clear, acc_en, c_wr_en;
    logic [AW-1:0] a_addr, b_addr, c_addr, i, j, k;

    matrix_mult_controller #(
        .AROWS(AR), .ACOLUMNS(AC), .BCOLUMNS(BC), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .acc_clear(acc_clear),
        .acc_en(acc_en), .c_wr_en(c_wr_en), .c_addr(c_addr), .c_wr_ready(c_wr_ready),
        .i(i), .j(j), .k(k)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit busy;
        bit done;
        bit rd_en;
        bit c_wr_en;
        int i;
        int j;
        int k;
    } rec_t;

    rec_t exp_q[$];
    bit   m_acc_en = 1'b0;
    bit   m_acc_clear = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    int   ready_mode = 0;
    int   stall_left = 0;
    bit   stall_done = 1'b0;
    int   stall_cycles = 0;
    int   stall_bad_addr = 0;

    int   a_mem[AR*AC];
    int   b_mem[AC*BC];
    int   c_ref[AR*BC];
    int   c_got[AR*BC];
    int   acc = 0;
    int   prev_a = 0;
    int   prev_b = 0;
    int   writes = 0;
    bit   sb_en = 1'b0;
    int   first_a = 0;
    int   first_b = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic rec_t mk(bit b, bit d, bit r, bit w, int ii, int jj, int kk);
        rec_t x;
        x.busy = b; x.done = d; x.rd_en = r; x.c_wr_en = w;
        x.i = ii; x.j = jj; x.k = kk;
        return x;
    endfunction

    function automatic rec_t cur_rec();
        if (exp_q.size() != 0) return exp_q[0];
        return mk(0, 0, 0, 0, 0, 0, 0);
    endfunction

    // One expected cycle per entry: AC reads, a drain, a write (repeated while stalled), then done.
    function automatic void build_pass();
        for (int ii = 0; ii < AR; ii++) begin
            for (int jj = 0; jj < BC; jj++) begin
                for (int kk = 0; kk < AC; kk++) exp_q.push_back(mk(1, 0, 1, 0, ii, jj, kk));
                exp_q.push_back(mk(1, 0, 0, 0, ii, jj, AC - 1));
                exp_q.push_back(mk(1, 0, 0, 1, ii, jj, AC - 1));
            end
        end
        exp_q.push_back(mk(1, 1, 0, 0, AR - 1, BC - 1, AC - 1));
    endfunction

    always @(posedge clock) begin : model
        rec_t c;
        c = cur_rec();
        if (reset) begin
            exp_q.delete();
            m_acc_en = 1'b0;
            m_acc_clear = 1'b0;
        end else begin
            m_acc_en = c.rd_en;
            m_acc_clear = c.rd_en && (c.k == 0);
            if (exp_q.size() == 0) begin
                if (start) build_pass();
            end else if (!(c.c_wr_en && !c_wr_ready)) begin
                void'(exp_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin : compare
        rec_t e;
        if (chk_en) begin
            e = cur_rec();
            checkOutput("busy", busy, e.busy);
            checkOutput("done", done, e.done);
            checkOutput("rd_en", rd_en, e.rd_en);
            checkOutput("c_wr_en", c_wr_en, e.c_wr_en);
            checkOutput("acc_en", acc_en, m_acc_en);
            checkOutput("acc_clear", acc_clear, m_acc_clear);
            checkOutput("i", i, e.i);
            checkOutput("j", j, e.j);
            checkOutput("k", k, e.k);
            checkOutput("a_addr", a_addr, e.i * AC + e.k);
            checkOutput("b_addr", b_addr, e.k * BC + e.j);
            checkOutput("c_addr", c_addr, e.i * BC + e.j);
        end
    end

    // MAC fed by memory data that arrives one cycle after the read strobe.
    always @(negedge clock) begin : mac
        int p;
        if (c_wr_en && !c_wr_ready) begin
            stall_cycles++;
            if (c_addr != 6) stall_bad_addr++;
        end
        if (sb_en) begin
            if (acc_en === 1'b1) begin
                p = a_mem[prev_a] * b_mem[prev_b];
                acc = (acc_clear === 1'b1) ? p : acc + p;
            end
            if (c_wr_en && c_wr_ready) begin
                if (int'(c_addr) < AR * BC) c_got[c_addr] = acc;
                writes++;
            end
        end
        prev_a = (int'(a_addr) < AR * AC) ? int'(a_addr) : 0;
        prev_b = (int'(b_addr) < AC * BC) ? int'(b_addr) : 0;
    end

    always @(posedge clock) begin : ready_driver
        #2;
        case (ready_mode)
            1: c_wr_ready = ($urandom_range(0, 2) != 0);
            2: begin
                if (stall_left > 0) begin
                    c_wr_ready = 1'b0;
                    stall_left--;
                end else if (!stall_done && c_wr_en && c_addr == 6) begin
                    c_wr_ready = 1'b0;
                    stall_left = 4;
                    stall_done = 1'b1;
                end else begin
                    c_wr_ready = 1'b1;
                end
            end
            3: c_wr_ready = 1'b0;
            default: c_wr_ready = 1'b1;
        endcase
    end

    task automatic applyStimulus(input bit s, input bit r);
        @(negedge clock);
        start = s;
        reset = r;
    endtask

    // n counts falling edges after the edge that samples start, up to the one showing done.
    task automatic runPass(input bit poke, output int n);
        bit seen;
        seen = 1'b0;
        applyStimulus(1, 0);
        n = 0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clock);
            start = 1'b0;
            n++;
            if (poke && n == 10) start = 1'b1;
            if (n == 2) begin
                first_a = int'(a_addr);
                first_b = int'(b_addr);
            end
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("pass_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        int  n;
        int  g;
        bit  seen;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_acc_en", acc_en, 0);
        applyStimulus(0, 0);
        @(negedge clock);

        // Plain pass, with a start pulse while busy that must be ignored.
        runPass(1, n);
        checkOutput("done_cycle", n, 41);
        checkOutput("done_cycle_formula", n, PASS_DONE);
        checkOutput("k1_a_addr", first_a, 1);
        checkOutput("k1_b_addr", first_b, 4);
        repeat (3) @(negedge clock);

        // Sink stalls element (1,2) for five cycles.
        stall_cycles = 0;
        stall_bad_addr = 0;
        stall_done = 1'b0;
        ready_mode = 2;
        runPass(0, n);
        ready_mode = 0;
        checkOutput("stall_done_cycle", n, 46);
        checkOutput("stall_cycles", stall_cycles, 5);
        checkOutput("stall_addr", stall_bad_addr, 0);
        repeat (2) @(negedge clock);

        // Reset mid-RUN at k==1 on the second row.
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (rd_en === 1'b1 && k == 1 && i == 1) seen = 1'b1;
        end
        if (!seen) checkOutput("reset_run_timeout", 0, 1);
        reset = 1'b1;
        applyStimulus(0, 0);
        checkOutput("rst_run_busy", busy, 0);
        checkOutput("rst_run_rd_en", rd_en, 0);
        checkOutput("rst_run_acc_en", acc_en, 0);
        checkOutput("rst_run_ijk", {i, j, k}, 0);
        runPass(0, n);
        checkOutput("restart_done_cycle", n, 41);
        repeat (2) @(negedge clock);

        // Reset mid-WRITE with the sink refusing.
        ready_mode = 3;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clock);
            if (c_wr_en === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("reset_write_timeout", 0, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        applyStimulus(0, 0);
        ready_mode = 0;
        checkOutput("rst_wr_c_wr_en", c_wr_en, 0);
        checkOutput("rst_wr_c_addr", c_addr, 0);

        // start together with reset is ignored.
        applyStimulus(1, 1);
        applyStimulus(0, 0);
        checkOutput("start_with_reset", busy, 0);
        @(negedge clock);
        checkOutput("start_with_reset_after", busy, 0);

        // start held high: one IDLE cycle between DONE and the next RUN.
        applyStimulus(1, 0);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("held_done_timeout", 0, 1);
        g = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            g++;
            if (rd_en === 1'b1) seen = 1'b1;
        end
        checkOutput("held_restart_gap", g, 2);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clock);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("held_second_timeout", 0, 1);
        repeat (3) @(negedge clock);
        checkOutput("held_back_idle", busy, 0);

        // Scoreboard pass over random operands and a random sink.
        for (int x = 0; x < AR * AC; x++) a_mem[x] = int'($urandom_range(0, 255));
        for (int x = 0; x < AC * BC; x++) b_mem[x] = int'($urandom_range(0, 255));
        for (int ii = 0; ii < AR; ii++) begin
            for (int jj = 0; jj < BC; jj++) begin
                c_ref[ii*BC+jj] = 0;
                for (int kk = 0; kk < AC; kk++)
                    c_ref[ii*BC+jj] += a_mem[ii*AC+kk] * b_mem[kk*BC+jj];
                c_got[ii*BC+jj] = -1;
            end
        end
        writes = 0;
        sb_en = 1'b1;
        ready_mode = 1;
        runPass(0, n);
        ready_mode = 0;
        sb_en = 1'b0;
        checkOutput("sb_writes", writes, AR * BC);
        for (int x = 0; x < AR * BC; x++) checkOutput($sformatf("sb_c%0d", x), c_got[x], c_ref[x]);

        repeat (3) @(negedge clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_mult_controller.md
MATRIX_MULT_CONTROLLER -- requirements
Module: matrix_mult_controller

Interface
REQ-001 Parameter AROWS, default 3: rows of A and of C.
REQ-002 Parameter ACOLUMNS, default 3: columns of A, rows of B, and MAC steps per C element.
REQ-003 Parameter BCOLUMNS, default 3: columns of B and of C.
REQ-004 Parameter ADDR_W, default 32: width of every address and index output.
REQ-005 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 start  in  1  request one full C = A x B pass; sampled only in IDLE.
REQ-009 busy  out  1  high in RUN, DRAIN, WRITE and DONE.
REQ-010 done  out  1  one-cycle pulse when the pass completes.
REQ-011 rd_en  out  1  A/B memory read strobe; memory data is valid one cycle later.
REQ-012 a_addr  out  ADDR_W  A address, i*ACOLUMNS+k (row-major).
REQ-013 b_addr  out  ADDR_W  B address, k*BCOLUMNS+j (row-major).
REQ-014 acc_clear  out  1  MAC loads the product instead of adding it (first term).
REQ-015 acc_en  out  1  MAC consumes the current memory data.
REQ-016 c_wr_en  out  1  C write request.
REQ-017 c_addr  out  ADDR_W  C address, i*BCOLUMNS+j.
REQ-018 c_wr_ready  in  1  C sink accepts the write when c_wr_en and c_wr_ready are both high.
REQ-019 i, j, k  out  ADDR_W each  current row, column and inner index.

Function
REQ-020 The FSM SHALL have states IDLE, RUN, DRAIN, WRITE and DONE.
REQ-021 IDLE: when start=1, clear i, j and k and go to RUN; otherwise stay in IDLE.
REQ-022 RUN: assert rd_en for (i,j,k); if k<ACOLUMNS-1 then k++ and stay in RUN, else go to DRAIN.
REQ-023 acc_en SHALL equal rd_en delayed one cycle; acc_clear SHALL equal (rd_en and k==0) delayed one cycle.
REQ-024 DRAIN: a one-cycle state carrying the acc_en of the last product; rd_en=0; then go to WRITE.
REQ-025 WRITE: c_wr_en=1 with c_addr stable until the handshake completes; the FSM holds WRITE while c_wr_ready=0.
REQ-026 On a WRITE handshake, if j<BCOLUMNS-1: j++, k=0, go to RUN.
REQ-027 On a WRITE handshake, else if i<AROWS-1: j=0, i++, k=0, go to RUN.
REQ-028 On a WRITE handshake, else go to DONE.
REQ-029 DONE: done=1 for exactly one cycle, then go to IDLE with i=j=k=0.
REQ-030 start SHALL be ignored outside IDLE; no queuing.
REQ-031 With c_wr_ready held at 1, each C element SHALL take ACOLUMNS+2 cycles; done SHALL rise AROWS*BCOLUMNS*(ACOLUMNS+2)+1 cycles after the edge that samples start.
REQ-032 ACOLUMNS=1 SHALL work: one RUN cycle with acc_clear=1 on the single product.
REQ-033 All parameters SHALL be >=1; address arithmetic is unsigned, truncated to ADDR_W.
REQ-034 rd_en, acc_en, acc_clear, c_wr_en and done SHALL never be X after reset.

Reset
REQ-035 reset=1 at any clock edge SHALL force IDLE with i=j=k=0.
REQ-036 reset SHALL force all 1-bit outputs and all addresses to 0 on the next cycle, including a reset mid-RUN or mid-WRITE.
REQ-037 The acc_en/acc_clear delay registers SHALL be cleared, so no stale acc_en appears after reset.
REQ-038 start asserted together with reset SHALL be ignored.

Verification
REQ-039 2x2x2, c_wr_ready=1, single start pulse -> rd_en addresses A:0,1 B:0,2 / A:0,1 B:1,3 / A:2,3 B:0,2 / A:2,3 B:1,3; c_addr 0,1,2,3; done at cycle 17.
REQ-040 AROWS=BCOLUMNS=2, ACOLUMNS=1 -> acc_clear=1 on every acc_en; each element takes 3 cycles; done at cycle 13.
REQ-041 3x3x3 with c_wr_ready=0 for 5 cycles on element (1,2) -> c_wr_en and c_addr=5 held for 5 cycles, no rd_en meanwhile; done delayed by exactly 5 cycles.
REQ-042 reset pulsed during RUN at k=1 -> next cycle busy=0, rd_en=acc_en=0, i=j=k=0; a new start restarts from address 0.
REQ-043 start held high continuously -> back-to-back passes with exactly one IDLE cycle between DONE and the next RUN; start pulses during busy cause no effect.
REQ-044 Scoreboard: a MAC model driven by acc_en/acc_clear over random A and B SHALL match a reference C for 1<=AROWS,ACOLUMNS,BCOLUMNS<=4 under random c_wr_ready.
